// File: rtl/atm_pkg.sv
// Shared types and constants for the ATM bill accumulator: denomination table,
// FSM state encoding and a one-hot test helper.
package atm_pkg;

   localparam int NUM_DENOM = 6;

   localparam logic [7:0] BILL_VALUE [NUM_DENOM] = '{8'd1, 8'd5, 8'd10, 8'd20, 8'd50, 8'd100};

   typedef enum logic [1:0] {
      IDLE,
      QUALIFY,
      WAIT_RELEASE
   } state_t;

   function automatic logic is_onehot(input logic [31:0] v);
      return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
   endfunction

endpackage

// File: rtl/atm_bill_accumulator_qualifier.sv
// Switch qualifier: registers the raw bill switches and counts consecutive
// identical samples to qualify an insertion or a release for the top-level FSM.
module atm_switch_qualifier
   import atm_pkg::*;
#(
   parameter int NUM_BILLS     = 6,
   parameter int STABLE_CYCLES = 4
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic [NUM_BILLS-1:0] i_bill_sw,
   input  state_t               i_state,
   input  logic                 i_abort,
   output logic                 o_sw_active,
   output logic                 o_qualified_valid,
   output logic [NUM_BILLS-1:0] o_qualified_pattern,
   output logic                 o_released
);

   localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(STABLE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

   logic [NUM_BILLS-1:0] r_sw_q;
   logic [NUM_BILLS-1:0] r_cand;
   logic [CNT_W-1:0]     r_cnt;
   logic                 w_same;

   assign o_sw_active         = |r_sw_q;
   assign o_qualified_pattern = r_cand;
   assign w_same              = (r_sw_q == r_cand);

   // The current sample is counted in the same cycle it completes the run, so the
   // decision lands on the edge where the count reaches STABLE_CYCLES.
   assign o_qualified_valid = (i_state == QUALIFY) &&
                              ((r_cnt == CNT_FULL) || (w_same && r_cnt == CNT_LAST));
   assign o_released        = (i_state == WAIT_RELEASE) &&
                              ((r_cnt == CNT_FULL) || (!o_sw_active && r_cnt == CNT_LAST));

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_sw_q <= '0;
         r_cand <= '0;
         r_cnt  <= '0;
      end else begin
         // NOTE: every register here uses <= so all reads see pre-edge values.
         r_sw_q <= i_bill_sw;
         unique case (i_state)
            IDLE: begin
               if (o_sw_active) begin
                  r_cand <= r_sw_q;
                  r_cnt  <= CNT_W'(1);
               end else begin
                  r_cnt <= '0;
               end
            end
            QUALIFY: begin
               if (o_qualified_valid || i_abort) r_cnt <= o_sw_active ? '0 : CNT_W'(1);
               else if (!o_sw_active)            r_cnt <= '0;
               else if (w_same)                  r_cnt <= r_cnt + CNT_W'(1);
               else begin
                  r_cand <= r_sw_q;
                  r_cnt  <= CNT_W'(1);
               end
            end
            WAIT_RELEASE: begin
               if (o_released || o_sw_active) r_cnt <= '0;
               else                           r_cnt <= r_cnt + CNT_W'(1);
            end
            default: r_cnt <= '0;
         endcase
      end
   end

endmodule

// File: rtl/atm_bill_accumulator.sv
// ATM bill accumulator: credits qualified bills into a saturating session total
// and finalises the session with deposit (commit) or refund (cancel) pulses.
module atm_bill_accumulator
   import atm_pkg::*;
#(
   parameter int NUM_BILLS     = 6,
   parameter int AMOUNT_W      = 16,
   parameter int MAX_TOTAL     = 999,
   parameter int STABLE_CYCLES = 4
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic [NUM_BILLS-1:0] i_bill_sw,
   input  logic                 i_commit,
   input  logic                 i_cancel,
   output logic [AMOUNT_W-1:0]  o_total,
   output logic [7:0]           o_last_bill,
   output logic                 o_multi_err,
   output logic                 o_overflow,
   output logic                 o_deposit_valid,
   output logic [AMOUNT_W-1:0]  o_deposit_amount,
   output logic                 o_refund_valid,
   output logic [AMOUNT_W-1:0]  o_refund_amount,
   output logic                 o_busy
);

   localparam int LOOKUP_N = (NUM_BILLS < NUM_DENOM) ? NUM_BILLS : NUM_DENOM;
   localparam logic [AMOUNT_W:0] MAX_EXT = (AMOUNT_W + 1)'(MAX_TOTAL);

   state_t               r_state;
   logic                 w_sw_active;
   logic                 w_qualified;
   logic                 w_released;
   logic                 w_req;
   logic [NUM_BILLS-1:0] w_pattern;
   logic [7:0]           w_value;
   logic [AMOUNT_W:0]    w_sum;

   assign w_req = i_commit | i_cancel;

   atm_switch_qualifier #(
      .NUM_BILLS     (NUM_BILLS),
      .STABLE_CYCLES (STABLE_CYCLES)
   ) u_qual (
      .i_clk               (i_clk),
      .i_reset             (i_reset),
      .i_bill_sw           (i_bill_sw),
      .i_state             (r_state),
      .i_abort             (w_req),
      .o_sw_active         (w_sw_active),
      .o_qualified_valid   (w_qualified),
      .o_qualified_pattern (w_pattern),
      .o_released          (w_released)
   );

   always_comb begin
      w_value = '0;
      for (int i = 0; i < LOOKUP_N; i++) begin
         if (w_pattern[i]) w_value = BILL_VALUE[i];
      end
   end

   // One extra bit keeps the limit compare free of wrap-around.
   assign w_sum = (AMOUNT_W + 1)'(o_total) + (AMOUNT_W + 1)'(w_value);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state          <= IDLE;
         o_busy           <= 1'b0;
         o_total          <= '0;
         o_last_bill      <= '0;
         o_multi_err      <= 1'b0;
         o_overflow       <= 1'b0;
         o_deposit_valid  <= 1'b0;
         o_deposit_amount <= '0;
         o_refund_valid   <= 1'b0;
         o_refund_amount  <= '0;
      end else begin
         o_overflow      <= 1'b0;
         o_deposit_valid <= 1'b0;
         o_refund_valid  <= 1'b0;

         if (i_cancel && o_total != '0) begin
            o_refund_valid  <= 1'b1;
            o_refund_amount <= o_total;
            o_total         <= '0;
         end else if (i_commit && o_total != '0) begin
            o_deposit_valid  <= 1'b1;
            o_deposit_amount <= o_total;
            o_total          <= '0;
         end

         unique case (r_state)
            IDLE: begin
               if (w_sw_active) begin
                  r_state <= QUALIFY;
                  o_busy  <= 1'b1;
               end
            end
            QUALIFY: begin
               if (w_req) begin
                  r_state <= WAIT_RELEASE;
               end else if (w_qualified) begin
                  r_state <= WAIT_RELEASE;
                  if (!is_onehot(32'(w_pattern))) begin
                     o_multi_err <= 1'b1;
                  end else if (w_sum <= MAX_EXT) begin
                     o_total     <= w_sum[AMOUNT_W-1:0];
                     o_last_bill <= w_value;
                  end else begin
                     o_overflow <= 1'b1;
                  end
               end else if (!w_sw_active) begin
                  r_state <= IDLE;
                  o_busy  <= 1'b0;
               end
            end
            WAIT_RELEASE: begin
               if (w_released) begin
                  r_state     <= IDLE;
                  o_busy      <= 1'b0;
                  o_multi_err <= 1'b0;
               end
            end
            default: begin
               r_state <= IDLE;
               o_busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/atm_bill_accumulator.md
Name: atm_bill_accumulator

Overview:
- Sequential successor to the combinational bill decoder.
- Qualifies a parametrised bank of one-hot bill switches, so that a switch must be stable for N cycles.
- Credits each qualified bill exactly once into a saturating running total.
- Flags multi-bill and over-limit insertions, and finalises the session with commit (deposit) or cancel (refund) handshake pulses toward the downstream account logic.

Parameters:
- NUM_BILLS, 6, number of bill switches; bit i maps to denomination entry i of the package table.
- AMOUNT_W, 16, width of total, deposit and refund amounts.
- MAX_TOTAL, 999, maximum session total. A bill that would exceed it is rejected. Must be less than 2**AMOUNT_W.
- STABLE_CYCLES, 4, consecutive identical samples needed to qualify an insertion or a release. Must be at least 1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- bill_sw  in  NUM_BILLS  raw bill switches; one-hot = one bill, zero = none.
- commit  in  1  single-cycle request to deposit the current total.
- cancel  in  1  single-cycle request to refund the current total.
- total  out  AMOUNT_W  running session total, registered.
- last_bill  out  8  value of the most recently credited bill.
- multi_err  out  1  level output; high while the qualified switch pattern has more than one bit set.
- overflow  out  1  one-cycle pulse when a qualified bill is rejected for exceeding MAX_TOTAL.
- deposit_valid  out  1  one-cycle pulse accompanying deposit_amount.
- deposit_amount  out  AMOUNT_W  total being deposited; valid only when deposit_valid is high.
- refund_valid  out  1  one-cycle pulse accompanying refund_amount.
- refund_amount  out  AMOUNT_W  total being refunded; valid only when refund_valid is high.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values:
  - total, last_bill, deposit_amount and refund_amount are 0.
  - All flags and pulses are 0.
  - FSM is in IDLE and the stability counter is 0.
- Sampling: bill_sw is registered once (sw_q). All decisions use sw_q, which gives 1 cycle of input latency.
- FSM states: IDLE, QUALIFY, WAIT_RELEASE.
- IDLE:
  - Exit when sw_q is nonzero. Go to QUALIFY, load the counter with 1 and latch sw_q as the candidate.
- QUALIFY:
  - If sw_q equals the candidate, increment the counter.
  - If sw_q changes to a different nonzero value, latch the new candidate and reload the counter to 1.
  - If sw_q goes to 0, return to IDLE with no credit.
  - When the counter reaches STABLE_CYCLES, act on the candidate and go to WAIT_RELEASE:
    - Candidate one-hot and total + value <= MAX_TOTAL: total += value on the next edge; last_bill = value.
    - Candidate one-hot and total + value > MAX_TOTAL: total unchanged; overflow pulses for 1 cycle.
    - Candidate multi-hot: no credit; multi_err is set. multi_err clears when WAIT_RELEASE exits.
- WAIT_RELEASE:
  - Return to IDLE after sw_q has been 0 for STABLE_CYCLES consecutive cycles.
  - Any nonzero sample restarts the release count.
  - A held bill is never credited twice.
- Latency: a bill held steadily from cycle t appears in total at cycle t+1+STABLE_CYCLES.
- Arithmetic: the add is performed at AMOUNT_W+1 bits before the compare, so there is no wrap-around. total never exceeds MAX_TOTAL.
- Commit and cancel:
  - Sampled every cycle in any state.
  - cancel has priority over commit when both are high in the same cycle.
  - commit with total > 0: next cycle deposit_valid = 1, deposit_amount = total, total = 0.
  - cancel with total > 0: next cycle refund_valid = 1, refund_amount = total, total = 0.
  - Either request with total = 0 produces no pulse.
  - If a commit or cancel coincides with a bill-credit cycle, the bill credit is dropped and the FSM goes to WAIT_RELEASE. The bill must be removed and reinserted.
  - If a commit or cancel arrives during QUALIFY, the FSM also goes to WAIT_RELEASE and the pending candidate is discarded.
- Reset mid-operation: takes effect on the next edge regardless of state. Any pending pulse is suppressed and total is lost (not refunded).
- Output timing: pulses are exactly 1 cycle. All outputs are registered.

Decomposition:
- Package atm_pkg:
  - Denomination table BILL_VALUE[0..5] = 1, 5, 10, 20, 50, 100 (8-bit each).
  - State enum for IDLE, QUALIFY, WAIT_RELEASE.
  - Helper function is_onehot.
- One natural sub-module, atm_switch_qualifier. It holds sw_q, the candidate register and the stability counter, and outputs qualified_valid, qualified_pattern and released.
- The accumulator, commit/cancel logic and FSM stay in the top.

Test Plan (all with STABLE_CYCLES = 4):
- Hold bill_sw = 6'b000100 for 10 cycles, then 0 for 6 cycles → total goes 0→10 exactly once, at cycle 5; last_bill = 10; busy goes low after the release.
- Glitch: 000010 for 2 cycles, then 0 → no credit; total stays 0 and the FSM returns to IDLE.
- Hold 6'b000101 for 6 cycles → multi_err = 1 from the qualify cycle until the release completes; total unchanged.
- Credit 9×100, then insert 100 with total = 900 → overflow pulses once and total stays 900. Then insert 50 → total = 950.
- With total = 35, assert commit and cancel in the same cycle → refund_valid = 1 with refund_amount = 35; deposit_valid = 0; total = 0.
- With total = 20, hold the $50 bill and pulse commit on its credit cycle → deposit_amount = 20 and total = 0. The bill is not credited until it is released and reinserted, after which total = 50.
